// File: rtl/cpu_pkg.sv
// Shared CPU definitions: CP0 exception codes, flush-controller state encoding,
// default handler entry and the victim EPC rule.
package cpu_pkg;

    localparam logic [4:0] EXC_INT = 5'h00;
    localparam logic [4:0] EXC_SYS = 5'h08;
    localparam logic [4:0] EXC_BP  = 5'h09;
    localparam logic [4:0] EXC_RI  = 5'h0A;
    localparam logic [4:0] EXC_OV  = 5'h0C;

    localparam logic [31:0] EXC_ENTRY_DEFAULT = 32'hBFC00380;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } flush_state_t;

    // A delay-slot victim restarts at its branch; the subtraction wraps modulo 2^32.
    function automatic logic [31:0] victim_epc(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/int_sync.sv
// Multi-flop synchronizer bringing the asynchronous hardware interrupt lines into clk.
module int_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] stage_reg [STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (reset) stage_reg[gi] <= '0;
                    else       stage_reg[gi] <= async_in;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (reset) stage_reg[gi] <= '0;
                    else       stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign sync_out = stage_reg[STAGES-1];

endmodule

// File: rtl/exc_flush_ctrl.sv
// Writeback-stage exception/interrupt/ERET controller: kills the victim, flushes
// the pipeline, commits CP0 state and redirects fetch with a ready handshake.
module exc_flush_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] EXC_ENTRY   = EXC_ENTRY_DEFAULT,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_valid,
    input  logic        ws_exc,
    input  logic [4:0]  ws_exc_code,
    input  logic        ws_eret,
    input  logic [31:0] ws_pc,
    input  logic        ws_bd,
    input  logic [31:0] cp0_epc,
    input  logic        cp0_ie,
    input  logic        cp0_exl,
    input  logic [5:0]  cp0_im,
    input  logic [5:0]  hw_int,
    input  logic        redirect_ready,
    output logic        kill_wb,
    output logic        ws_hold,
    output logic        flush,
    output logic        cp0_commit,
    output logic [4:0]  cp0_code,
    output logic [31:0] cp0_epc_wr,
    output logic        cp0_bd,
    output logic        cp0_eret,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    flush_state_t state_reg;
    logic         flush_reg;
    logic         cp0_commit_reg;
    logic         cp0_eret_reg;
    logic [4:0]   cp0_code_reg;
    logic [31:0]  cp0_epc_wr_reg;
    logic         cp0_bd_reg;
    logic         redirect_valid_reg;
    logic [31:0]  redirect_pc_reg;

    logic [5:0]   hw_int_sync;
    logic         int_pend;
    logic         in_idle;
    logic         event_now;
    logic         is_eret;

    int_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (6)
    ) u_int_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (hw_int),
        .sync_out (hw_int_sync)
    );

    assign int_pend  = cp0_ie & ~cp0_exl & (|(cp0_im & hw_int_sync));
    assign in_idle   = (state_reg == ST_IDLE);
    assign event_now = in_idle & ws_valid & (ws_exc | int_pend | ws_eret);
    // ERET only wins when neither an exception nor an interrupt is present.
    assign is_eret   = ~ws_exc & ~int_pend & ws_eret;
    assign kill_wb   = in_idle & ws_valid & (ws_exc | int_pend);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= ST_IDLE;
            flush_reg          <= 1'b0;
            cp0_commit_reg     <= 1'b0;
            cp0_eret_reg       <= 1'b0;
            cp0_code_reg       <= '0;
            cp0_epc_wr_reg     <= '0;
            cp0_bd_reg         <= 1'b0;
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (event_now) begin
                        state_reg      <= ST_FLUSH;
                        flush_reg      <= 1'b1;
                        cp0_commit_reg <= ~is_eret;
                        cp0_eret_reg   <= is_eret;
                        if (!is_eret) begin
                            cp0_code_reg   <= ws_exc ? ws_exc_code : EXC_INT;
                            cp0_epc_wr_reg <= victim_epc(ws_pc, ws_bd);
                            cp0_bd_reg     <= ws_bd;
                        end
                        // Target is frozen now so later EPC/interrupt changes cannot retarget.
                        redirect_pc_reg <= is_eret ? cp0_epc : EXC_ENTRY;
                    end
                end
                ST_FLUSH: begin
                    state_reg          <= ST_REDIRECT;
                    flush_reg          <= 1'b0;
                    cp0_commit_reg     <= 1'b0;
                    cp0_eret_reg       <= 1'b0;
                    redirect_valid_reg <= 1'b1;
                end
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        state_reg          <= ST_IDLE;
                        redirect_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg          <= ST_IDLE;
                    flush_reg          <= 1'b0;
                    cp0_commit_reg     <= 1'b0;
                    cp0_eret_reg       <= 1'b0;
                    redirect_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign ws_hold        = ~in_idle;
    assign flush          = flush_reg;
    assign cp0_commit     = cp0_commit_reg;
    assign cp0_eret       = cp0_eret_reg;
    assign cp0_code       = cp0_code_reg;
    assign cp0_epc_wr     = cp0_epc_wr_reg;
    assign cp0_bd         = cp0_bd_reg;
    assign redirect_valid = redirect_valid_reg;
    assign redirect_pc    = redirect_pc_reg;

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// Bench for exc_flush_ctrl: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against an event-level model.
module tb_exc_flush_ctrl;
    import cpu_pkg::*;

    localparam int          SYNC  = 2;
    localparam logic [31:0] ENTRY = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_valid, ws_exc, ws_eret, ws_bd;
    logic [4:0]  ws_exc_code;
    logic [31:0] ws_pc, cp0_epc;
    logic        cp0_ie, cp0_exl;
    logic [5:0]  cp0_im, hw_int;
    logic        redirect_ready;
    logic        kill_wb, ws_hold, flush, cp0_commit, cp0_bd, cp0_eret, redirect_valid;
    logic [4:0]  cp0_code;
    logic [31:0] cp0_epc_wr, redirect_pc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exc_flush_ctrl #(.EXC_ENTRY(ENTRY), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset),
        .ws_valid(ws_valid), .ws_exc(ws_exc), .ws_exc_code(ws_exc_code), .ws_eret(ws_eret),
        .ws_pc(ws_pc), .ws_bd(ws_bd), .cp0_epc(cp0_epc), .cp0_ie(cp0_ie), .cp0_exl(cp0_exl),
        .cp0_im(cp0_im), .hw_int(hw_int), .redirect_ready(redirect_ready),
        .kill_wb(kill_wb), .ws_hold(ws_hold), .flush(flush), .cp0_commit(cp0_commit),
        .cp0_code(cp0_code), .cp0_epc_wr(cp0_epc_wr), .cp0_bd(cp0_bd), .cp0_eret(cp0_eret),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    // Event-level model: an accepted event is followed by one flush cycle, then a
    // redirect offer held until accepted; the synchronizer is a SYNC-deep history.
    logic        m_known = 1'b0;
    logic        m_busy, m_eret, m_bd, m_after_rst;
    int          m_age;
    logic [4:0]  m_code;
    logic [31:0] m_epc, m_target;
    logic [5:0]  hist [SYNC];

    always @(negedge clk) begin
        logic ipend, ev;
        ipend = 1'b0;
        ev    = 1'b0;
        if (m_known) begin
            ipend = cp0_ie && !cp0_exl && ((cp0_im & hist[SYNC-1]) != 6'd0);
            if (!m_busy) begin
                ev = ws_valid && (ws_exc || ipend || ws_eret);
                chk("m_kill_wb", kill_wb, ws_valid && (ws_exc || ipend));
                chk("m_ws_hold", ws_hold, 0);
                chk("m_flush", flush, 0);
                chk("m_commit", cp0_commit, 0);
                chk("m_eret", cp0_eret, 0);
                chk("m_rvalid", redirect_valid, 0);
            end else if (m_age == 1) begin
                chk("m_kill_wb", kill_wb, 0);
                chk("m_ws_hold", ws_hold, 1);
                chk("m_flush", flush, 1);
                chk("m_commit", cp0_commit, !m_eret);
                chk("m_eret", cp0_eret, m_eret);
                chk("m_rvalid", redirect_valid, 0);
                if (!m_eret) begin
                    chk("m_code", cp0_code, m_code);
                    chk("m_epc_wr", cp0_epc_wr, m_epc);
                    chk("m_bd", cp0_bd, m_bd);
                end
            end else begin
                chk("m_kill_wb", kill_wb, 0);
                chk("m_ws_hold", ws_hold, 1);
                chk("m_flush", flush, 0);
                chk("m_commit", cp0_commit, 0);
                chk("m_eret", cp0_eret, 0);
                chk("m_rvalid", redirect_valid, 1);
                chk("m_rpc", redirect_pc, m_target);
            end
            if (m_after_rst) begin
                chk("m_rst_rpc", redirect_pc, 0);
                chk("m_rst_code", cp0_code, 0);
                chk("m_rst_epc", cp0_epc_wr, 0);
                chk("m_rst_bd", cp0_bd, 0);
            end
        end
        if (reset) begin
            m_known     = 1'b1;
            m_busy      = 1'b0;
            m_after_rst = 1'b1;
            for (int i = 0; i < SYNC; i++) hist[i] = 6'd0;
        end else if (m_known) begin
            m_after_rst = 1'b0;
            if (!m_busy && ev) begin
                m_busy   = 1'b1;
                m_age    = 1;
                m_eret   = !ws_exc && !ipend;
                m_code   = ws_exc ? ws_exc_code : 5'h00;
                m_bd     = ws_bd;
                m_epc    = ws_bd ? ws_pc - 32'd4 : ws_pc;
                m_target = m_eret ? cp0_epc : ENTRY;
                $display("event t=%0t kind=%s code=%h epc=%h target=%h", $time,
                         m_eret ? "eret" : (ws_exc ? "exc" : "int"), m_code, m_epc, m_target);
            end else if (m_busy && m_age == 1) begin
                m_age = 2;
            end else if (m_busy && redirect_ready) begin
                m_busy = 1'b0;
            end
            for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = hw_int;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        ws_valid = 0; ws_exc = 0; ws_eret = 0; ws_bd = 0; hw_int = 6'd0;
        ws_exc_code = 5'd0; ws_pc = 32'd0;
    endtask

    task automatic fire_exc(input logic [31:0] pc, input logic bd, input logic [4:0] code);
        ws_valid = 1; ws_exc = 1; ws_exc_code = code; ws_pc = pc; ws_bd = bd;
    endtask

    logic [4:0] codes [4];

    initial begin
        codes[0] = EXC_SYS; codes[1] = EXC_BP; codes[2] = EXC_RI; codes[3] = EXC_OV;
        reset = 1; quiet();
        cp0_epc = 32'd0; cp0_ie = 0; cp0_exl = 0; cp0_im = 6'd0; redirect_ready = 1;
        repeat (3) tick();
        reset = 0;
        tick();

        // SYSCALL, not in a delay slot
        fire_exc(32'hBFC00100, 1'b0, EXC_SYS);
        #2 chk("sys_kill_T", kill_wb, 1);
        tick(); quiet();
        #2 chk("sys_flush", flush, 1); chk("sys_commit", cp0_commit, 1);
        chk("sys_code", cp0_code, 32'h8); chk("sys_epc", cp0_epc_wr, 32'hBFC00100);
        tick();
        #2 chk("sys_rvalid", redirect_valid, 1); chk("sys_rpc", redirect_pc, 32'hBFC00380);
        tick();
        #2 chk("sys_back_idle", ws_hold, 0);
        $display("scenario syscall done");

        // Delay-slot victim
        fire_exc(32'h80000010, 1'b1, EXC_RI);
        tick(); quiet();
        #2 chk("bd_epc", cp0_epc_wr, 32'h8000000C); chk("bd_flag", cp0_bd, 1);
        repeat (2) tick();
        $display("scenario delay-slot done");

        // EPC wraps when pc=0 in a delay slot
        fire_exc(32'h0, 1'b1, EXC_OV);
        tick(); quiet();
        #2 chk("wrap_epc", cp0_epc_wr, 32'hFFFFFFFC);
        repeat (2) tick();
        $display("scenario epc-wrap done");

        // ERET: EPC sampled in the event cycle, later change ignored
        cp0_epc = 32'h80001000; ws_valid = 1; ws_eret = 1;
        #2 chk("eret_nokill", kill_wb, 0);
        tick(); quiet(); cp0_epc = 32'h12345678;
        #2 chk("eret_pulse", cp0_eret, 1); chk("eret_nocommit", cp0_commit, 0);
        tick();
        #2 chk("eret_rpc", redirect_pc, 32'h80001000);
        tick();
        $display("scenario eret done");

        // Interrupt through the synchronizer
        cp0_ie = 1; cp0_exl = 0; cp0_im = 6'h01; ws_valid = 1; ws_pc = 32'h80000200; hw_int = 6'h01;
        #2 chk("int_c0_nokill", kill_wb, 0);
        tick();
        #2 chk("int_c1_nokill", kill_wb, 0);
        tick();
        #2 chk("int_c2_kill", kill_wb, 1);
        tick(); quiet();
        #2 chk("int_commit", cp0_commit, 1); chk("int_code", cp0_code, 0);
        repeat (2) tick();
        $display("scenario interrupt done");

        // EXL masks interrupts
        cp0_exl = 1; ws_valid = 1; hw_int = 6'h01;
        repeat (5) begin
            tick();
            #2 chk("exl_nokill", kill_wb, 0); chk("exl_nohold", ws_hold, 0);
        end
        quiet(); cp0_exl = 0; cp0_ie = 0;
        repeat (3) tick();
        $display("scenario exl-mask done");

        // Fetch stalls the redirect for 5 cycles
        redirect_ready = 0;
        fire_exc(32'h80000400, 1'b0, EXC_BP);
        tick(); quiet();
        repeat (5) begin
            tick();
            #2 chk("stall_rvalid", redirect_valid, 1); chk("stall_rpc", redirect_pc, ENTRY);
            chk("stall_hold", ws_hold, 1);
        end
        tick(); redirect_ready = 1;
        #2 chk("stall_accept_rvalid", redirect_valid, 1);
        tick();
        #2 chk("stall_idle", ws_hold, 0); chk("stall_rvalid_low", redirect_valid, 0);
        $display("scenario redirect-stall done");

        // Reset while in FLUSH
        fire_exc(32'h80000500, 1'b0, EXC_SYS);
        tick(); quiet(); reset = 1;
        #2 chk("rst_in_flush", flush, 1);
        tick(); reset = 0;
        #2 chk("rst_flush0", flush, 0); chk("rst_rvalid0", redirect_valid, 0);
        chk("rst_commit0", cp0_commit, 0); chk("rst_hold0", ws_hold, 0); chk("rst_rpc0", redirect_pc, 0);
        tick();
        #2 chk("rst_after_commit", cp0_commit, 0); chk("rst_after_rvalid", redirect_valid, 0);
        $display("scenario reset-in-flush done");

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            tick();
            reset          = ($urandom_range(0, 199) == 0);
            ws_valid       = ($urandom_range(0, 2) != 0);
            ws_exc         = ($urandom_range(0, 9) == 0);
            ws_exc_code    = codes[$urandom_range(0, 3)];
            ws_eret        = ($urandom_range(0, 7) == 0);
            ws_pc          = ($urandom_range(0, 19) == 0) ? 32'd0 : ($urandom & 32'hFFFFFFFC);
            ws_bd          = $urandom_range(0, 1);
            cp0_epc        = $urandom;
            cp0_ie         = ($urandom_range(0, 3) != 0);
            cp0_exl        = ($urandom_range(0, 3) == 0);
            cp0_im         = 6'($urandom);
            if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom & $urandom & $urandom);
            redirect_ready = ($urandom_range(0, 3) != 0);
        end
        tick(); quiet(); reset = 0; redirect_ready = 1;
        repeat (5) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exc_flush_ctrl.md
EXC_FLUSH_CTRL -- requirements
Module: exc_flush_ctrl

Interface
REQ-001 SHALL have parameter: EXC_ENTRY, 32'hBFC00380, exception/interrupt handler entry PC.
REQ-002 SHALL have parameter: SYNC_STAGES, 2, flop depth of hardware-interrupt synchronizer.
REQ-003 SHALL have ports: clk  in  1  clock; reset  in  1  synchronous, active-high.
REQ-004 SHALL have ports: ws_valid  in  1  WB holds an instruction; ws_exc  in  1  instruction carries exception; ws_exc_code  in  5  ExcCode; ws_eret  in  1  instruction is ERET.
REQ-005 SHALL have ports: ws_pc  in  32  WB PC; ws_bd  in  1  WB instruction in delay slot; cp0_epc  in  32  current EPC; cp0_ie  in  1  Status.IE; cp0_exl  in  1  Status.EXL; cp0_im  in  6  Status.IM[7:2].
REQ-006 SHALL have ports: hw_int  in  6  asynchronous hardware interrupt lines; redirect_ready  in  1  fetch accepts redirect.
REQ-007 SHALL have ports: kill_wb  out  1  suppress RF/CP0 write of current WB instruction; ws_hold  out  1  WB must not accept; flush  out  1  squash all stages.
REQ-008 SHALL have ports: cp0_commit  out  1  write Cause/EPC/EXL; cp0_code  out  5; cp0_epc_wr  out  32; cp0_bd  out  1; cp0_eret  out  1  clear EXL; redirect_valid  out  1; redirect_pc  out  32.

Function
REQ-009 SHALL implement FSM IDLE, FLUSH, REDIRECT; reset state IDLE.
REQ-010 SHALL compute int_pend = ie & !exl & |(im & hw_int_sync).
REQ-011 SHALL detect event in IDLE when ws_valid & (ws_exc | int_pend | ws_eret); priority exception > interrupt > eret.
REQ-012 SHALL drive kill_wb combinationally high in the event cycle for exception/interrupt only (ERET not killed).
REQ-013 SHALL, on event in cycle T, latch kind, code (interrupt = 5'h00), bd, and EPC (ws_pc-4 when ws_bd, else ws_pc) and move to FLUSH at T+1.
REQ-014 SHALL in FLUSH assert flush for exactly one cycle and pulse cp0_commit (exception/interrupt) or cp0_eret (eret), then go to REDIRECT.
REQ-015 SHALL in REDIRECT hold redirect_valid=1 with redirect_pc = EXC_ENTRY, or cp0_epc sampled at T for eret, stable until redirect_ready; return to IDLE the cycle after handshake.
REQ-016 SHALL drive ws_hold = (state != IDLE); ws_valid ignored outside IDLE.
REQ-017 SHALL compute EPC modulo 2^32 (ws_pc=0 with bd gives 32'hFFFFFFFC).
REQ-018 SHALL keep back-to-back events at least 3 cycles apart (minimum, redirect_ready already high).
REQ-019 SHALL not let hw_int changes after T alter the in-flight event.

Reset
REQ-020 SHALL, on reset (including mid-sequence), return to IDLE with all outputs 0, redirect_pc 0, synchronizer flops 0, next cycle.
REQ-021 SHALL keep no latched event across reset; a pending redirect is dropped.

Structure
REQ-022 SHALL place ExcCode constants (INT 5'h00, SYS 5'h08, BP 5'h09, RI 5'h0A, OV 5'h0C), FSM encoding, and default EXC_ENTRY in shared package cpu_pkg.
REQ-023 SHALL instantiate one sub-module int_sync (parameterised SYNC_STAGES x 6-bit synchronizer).

Verification
REQ-024 SHALL cover SYSCALL: ws_pc=32'hBFC00100, exc code 8, bd=0 -> kill_wb at T, flush+cp0_commit at T+1 with code 8, EPC BFC00100, redirect_pc BFC00380 at T+2.
REQ-025 SHALL cover delay slot: ws_pc=32'h80000010, bd=1 -> cp0_epc_wr 8000000C, cp0_bd=1.
REQ-026 SHALL cover ERET: cp0_epc=32'h80001000 -> no kill_wb, cp0_eret at T+1, redirect_pc 80001000.
REQ-027 SHALL cover interrupt: hw_int[0]=1, im=6'h01, ie=1, exl=0 -> event no earlier than 2 cycles later, code 0; with exl=1 -> no event.
REQ-028 SHALL cover redirect_ready low 5 cycles -> redirect_valid/pc stable, ws_hold high throughout, IDLE one cycle after accept.
REQ-029 SHALL cover reset in FLUSH -> IDLE, flush/redirect_valid 0 next cycle, no cp0_commit.
